// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// uart_tx_arbiter (rev 1.0): round-robin arbiter sharing one 8N1 UART TX line among N_REQ requesters.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int CLKS_PER_BIT = 16,
  parameter int GW           = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               txd,
  output logic               busy,
  output logic [GW-1:0]      grant_idx
);

  localparam int              PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0]   LAST_RST  = PW'(N_REQ - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   baud, baud_nxt;
  logic [2:0]    bit_cnt, cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [PW-1:0] last;
  logic [PW-1:0] winner;
  logic          found;
  logic [7:0]    win_data;
  logic          bit_end;
  logic          window_open;
  logic          handshake;
  logic          txd_nxt;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int k);
    int sum;
    sum = (int'(base) + k) % N_REQ;
    return PW'(sum);
  endfunction

  // Walk the search order backwards so the earliest valid slot after `last` is assigned last.
  always_comb begin
    winner = last;
    found  = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[rr_index(last, k)]) begin
        winner = rr_index(last, k);
        found  = 1'b1;
      end
    end
  end

  assign win_data    = req_data[int'(winner)*8 +: 8];
  assign bit_end     = (baud == BAUD_LAST);
  assign window_open = (state == IDLE) || ((state == STOP) && bit_end);
  assign handshake   = window_open && found;
  assign req_ready   = handshake ? (N_REQ'(1) << winner) : '0;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    baud_nxt  = ((state == IDLE) || bit_end) ? 16'd0 : baud + 16'd1;
    shift_nxt = shift;
    cnt_nxt   = bit_cnt;
    txd_nxt   = 1'b1;
    case (state)
      IDLE: ;
      START: if (bit_end) state_nxt = DATA;
      DATA: begin
        if (bit_end) begin
          shift_nxt = shift >> 1;
          cnt_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_nxt = STOP;
`endif
      STOP: if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A handshake in IDLE or the last STOP cycle overrides and starts a fresh frame.
    if (handshake) begin
      state_nxt = START;
      baud_nxt  = 16'd0;
      shift_nxt = win_data;
      cnt_nxt   = 3'd0;
    end
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_nxt = parity;
`endif
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud      <= 16'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'd0;
      last      <= LAST_RST;
      grant_idx <= '0;
      txd       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_cnt <= cnt_nxt;
      shift   <= shift_nxt;
      txd     <= txd_nxt;
      if (handshake) begin
        last      <= winner;
        grant_idx <= GW'(winner);
`ifdef UART_TX_PARITY_EN
        parity    <= ^win_data;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// tb_uart_tx_arbiter: expected (requester, byte) pairs are queued as stimulus is driven and
// popped as a line receiver decodes each frame from txd.
module tb_uart_tx_arbiter;
  localparam int N   = 3;
  localparam int CPB = 4;
  localparam int GW  = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           txd;
  logic           busy;
  logic [GW-1:0]  grant_idx;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           rdy_pulses = 0;
  logic [N-1:0] rdy_last = '0;
  int           s0, s1, s2;

  uart_tx_arbiter #(.N_REQ(N), .CLKS_PER_BIT(CPB), .GW(GW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .txd(txd), .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (|req_ready) begin
      rdy_pulses++;
      rdy_last = req_ready;
    end
  endtask

  task automatic expect_frame(input int idx, input logic [7:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    req_data[8*i +: 8] = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check_eq("rst_txd", 32'(txd), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_grant", 32'(grant_idx), 0);
    check_eq("rst_ready", 32'(req_ready), 0);
    reset = 1'b0;
  endtask

  // Decodes one frame; returns at the last cycle of the stop bit.
  task automatic rx_frame(output int start_cyc);
    int         waited;
    logic [7:0] b;
    logic       par;
    exp_t       e;
    waited = 0;
    par    = 1'b0;
    while (txd !== 1'b0 && waited < 4 * FRAME) begin
      tick();
      waited++;
    end
    start_cyc = cyc;
    if (txd !== 1'b0) begin
      check_eq("rx_start_seen", 32'(txd), 0);
      return;
    end
    check_eq("busy_at_start", 32'(busy), 1);
    rdy_pulses = 0;
    rdy_last   = '0;
    repeat (CPB / 2) tick();
    check_eq("start_bit", 32'(txd), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      b[i] = txd;
    end
`ifdef UART_TX_PARITY_EN
    repeat (CPB) tick();
    par = txd;
`endif
    repeat (CPB) tick();
    check_eq("stop_bit", 32'(txd), 1);
    repeat (CPB / 2 - 1) tick();
    check_eq("busy_at_end", 32'(busy), 1);
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 32'(sb.size()), 1);
      return;
    end
    e = sb.pop_front();
    check_eq("rx_byte", 32'(b), 32'(e.data));
    check_eq("grant_idx", 32'(grant_idx), 32'(e.idx));
`ifdef UART_TX_PARITY_EN
    check_eq("parity_bit", 32'(par), 32'(^e.data));
`else
    check_eq("parity_unused", 32'(par), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single byte from requester 0.
    apply_reset();
    set_data(0, 8'hA5);
    req_valid = 3'b001;
    #1 check_eq("t1_ready", 32'(req_ready), 32'b001);
    expect_frame(0, 8'hA5);
    @(negedge clk);
    req_valid = '0;
    rx_frame(s0);
    check_eq("t1_no_regrant", 32'(rdy_pulses), 0);
    tick();
    check_eq("t1_busy_fall", 32'(busy), 0);
    check_eq("t1_txd_idle", 32'(txd), 1);

    // Round-robin fairness with everyone pending, back-to-back.
    apply_reset();
    set_data(0, 8'h11);
    set_data(1, 8'h22);
    set_data(2, 8'h33);
    req_valid = 3'b111;
    #1 check_eq("t2_ready_first", 32'(req_ready), 32'b001);
    for (int k = 0; k < 6; k++) expect_frame(k % 3, 8'h11 * 8'((k % 3) + 1));
    for (int k = 0; k < 6; k++) begin
      rx_frame(s1);
      if (k > 0) check_eq("t2_gap", 32'(s1 - s0), 32'(FRAME));
      check_eq("t2_ready_count", 32'(rdy_pulses), 1);
      check_eq("t2_ready_next", 32'(rdy_last), 32'(1 << ((k + 1) % 3)));
      if (k == 5) req_valid = '0;
      s0 = s1;
    end
    tick();
    check_eq("t2_busy_fall", 32'(busy), 0);

    // Rotation skips an idle requester: after 0, requester 2 precedes 0.
    apply_reset();
    set_data(0, 8'h5A);
    set_data(2, 8'hC3);
    req_valid = 3'b001;
    #1 expect_frame(0, 8'h5A);
    @(negedge clk);
    req_valid = 3'b101;
    expect_frame(2, 8'hC3);
    expect_frame(0, 8'h5A);
    rx_frame(s0);
    check_eq("t3_ready_to_2", 32'(rdy_last), 32'b100);
    rx_frame(s1);
    check_eq("t3_gap", 32'(s1 - s0), 32'(FRAME));
    check_eq("t3_ready_to_0", 32'(rdy_last), 32'b001);
    tick();
    req_valid = '0;
    rx_frame(s2);
    check_eq("t3_no_regrant", 32'(rdy_pulses), 0);

    // Requester 1 withdraws before the accept window opens.
    apply_reset();
    set_data(0, 8'h07);
    req_valid = 3'b001;
    #1 expect_frame(0, 8'h07);
    @(negedge clk);
    req_valid = '0;
    fork
      rx_frame(s0);
      begin
        repeat (8) @(negedge clk);
        #1;
        set_data(1, 8'h99);
        req_valid[1] = 1'b1;
        repeat (20) @(negedge clk);
        #1 req_valid[1] = 1'b0;
      end
    join
    check_eq("t4_never_ready", 32'(rdy_pulses), 0);
    tick();
    check_eq("t4_busy_fall", 32'(busy), 0);
    check_eq("t4_txd_idle", 32'(txd), 1);
    repeat (3) tick();
    check_eq("t4_stays_idle", 32'(busy), 0);
    check_eq("t4_sb_empty", 32'(sb.size()), 0);

    // Reset during data bit 3 aborts the frame and restores the pointer.
    apply_reset();
    set_data(0, 8'h00);
    req_valid = 3'b001;
    @(negedge clk);
    req_valid = '0;
    repeat (17) @(negedge clk);
    check_eq("t5_mid_frame_txd", 32'(txd), 0);
    check_eq("t5_mid_frame_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t5_abort_txd", 32'(txd), 1);
    check_eq("t5_abort_busy", 32'(busy), 0);
    check_eq("t5_abort_ready", 32'(req_ready), 0);
    reset = 1'b0;
    set_data(0, 8'h3C);
    set_data(2, 8'h81);
    req_valid = 3'b101;
    #1 check_eq("t5_ptr_reset", 32'(req_ready), 32'b001);
    expect_frame(0, 8'h3C);
    @(negedge clk);
    req_valid = '0;
    rx_frame(s0);

    // A lone continuous requester gets every slot; data may change before each accept.
    apply_reset();
    set_data(1, 8'h07);
    req_valid = 3'b010;
    #1 check_eq("t6_ready", 32'(req_ready), 32'b010);
    expect_frame(1, 8'h07);
    @(negedge clk);
    set_data(1, 8'h03);
    expect_frame(1, 8'h03);
    rx_frame(s0);
    check_eq("t6_ready_again", 32'(rdy_last), 32'b010);
    tick();
    set_data(1, 8'hE1);
    expect_frame(1, 8'hE1);
    rx_frame(s1);
    check_eq("t6_gap1", 32'(s1 - s0), 32'(FRAME));
    tick();
    rx_frame(s2);
    check_eq("t6_gap2", 32'(s2 - s1), 32'(FRAME));
    req_valid = '0;
    tick();
    check_eq("t6_busy_fall", 32'(busy), 0);
    check_eq("t6_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
